// File: rtl/hw_decoder_seq.sv
// Registered SEL_W:OUT_W decoder with one-hot, thermometer, active-low one-hot and
// walking-one scan modes behind a valid/ready request handshake.
module hw_decoder_seq #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] q,
    output logic             q_valid,
    output logic             scan_wrap,
    output logic             sel_err
);

    localparam logic [1:0] ModeOnehot  = 2'b00;
    localparam logic [1:0] ModeTherm   = 2'b01;
    localparam logic [1:0] ModeScan    = 2'b10;
    localparam logic [1:0] ModeOnehotN = 2'b11;

    localparam logic [SEL_W:0]   OutWide = (SEL_W + 1)'(OUT_W);
    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(OUT_W - 1);

    typedef enum logic [1:0] {StIdle, StHold, StScan} state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   q_q, q_d;
    logic               qv_q, qv_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   idx_nx;
    logic               accept;
    logic               out_of_range;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [OUT_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < OUT_W; i++) v[i] = (SEL_W'(i) == sel);
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] therm(input logic [SEL_W-1:0] sel);
        logic [OUT_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < OUT_W; i++) v[i] = (SEL_W'(i) <= sel);
        return v;
    endfunction

    // Reset is folded in so a requester never sees ready while the block is held in reset.
    assign in_ready     = rst_n & EN & (state_q != StScan);
    assign accept       = in_valid & in_ready;
    assign out_of_range = ({1'b0, s} >= OutWide);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qv_d    = qv_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        idx_nx  = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;

        if (!EN) begin
            state_d = StIdle;
            q_d     = '0;
            qv_d    = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (state_q == StScan) begin
            // cnt_q counts steps taken since the first pattern; OUT_W patterns in total.
            if (cnt_q == LastIdx) begin
                state_d = StIdle;
                q_d     = '0;
                qv_d    = 1'b0;
                idx_d   = '0;
                cnt_d   = '0;
            end else begin
                idx_d  = idx_nx;
                q_d    = onehot(idx_nx);
                cnt_d  = cnt_q + 1'b1;
                wrap_d = (idx_nx == '0);
            end
        end else if (accept) begin
            if (out_of_range) begin
                state_d = StIdle;
                q_d     = '0;
                qv_d    = 1'b0;
                err_d   = 1'b1;
            end else begin
                qv_d    = 1'b1;
                state_d = StHold;
                unique case (mode)
                    ModeOnehot:  q_d = onehot(s);
                    ModeTherm:   q_d = therm(s);
                    ModeOnehotN: q_d = ~onehot(s);
                    ModeScan: begin
                        q_d     = onehot(s);
                        idx_d   = s;
                        cnt_d   = '0;
                        state_d = StScan;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            q_q     <= '0;
            qv_q    <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q         = q_q;
    assign q_valid   = qv_q;
    assign scan_wrap = wrap_q;
    assign sel_err   = err_q;

endmodule
